// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: default widths, state encoding
// and byte-lane select values.
package lsu_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int RD_W_DEF   = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD      = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR      = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_RD      = ST_RD,
        S_RD_WAIT = ST_RD_WAIT,
        S_WR      = ST_WR,
        S_RESP    = ST_RESP
    } lsu_state_t;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;
endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane datapath: extracts and extends a loaded byte, and merges a store
// byte into the word read back from memory. Little-endian lanes, 16-bit words.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic        is_byte,
    input  logic        is_signed,
    input  logic        addr0,
    input  logic [15:0] word,
    input  logic [7:0]  wbyte,
    output logic [15:0] ext_data,
    output logic [15:0] merged
);
    logic [7:0] lane;

    always_comb begin
        lane = (addr0 == LANE_HI) ? word[15:8] : word[7:0];
        if (is_byte)
            ext_data = {{8{is_signed & lane[7]}}, lane};
        else
            ext_data = word;
        merged = (addr0 == LANE_HI) ? {wbyte, word[7:0]} : {word[15:8], wbyte};
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a single-port, word-addressed data memory with a
// one-cycle registered read. Byte stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int   ADDR_W     = ADDR_W_DEF,
    parameter int   DATA_W     = DATA_W_DEF,
    parameter int   RD_W       = RD_W_DEF,
    parameter logic BYTE_ST_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [RD_W-1:0]   rsp_rd,
    output logic              rsp_load,
    output logic              rsp_err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    lsu_state_t        state;
    logic              we_q;
    logic              byte_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [RD_W-1:0]   rd_q;
    logic [DATA_W-1:0] wbuf;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] merged;
    logic              bad_req;

    lsu_byte_lane u_lane (
        .is_byte   (byte_q),
        .is_signed (signed_q),
        .addr0     (addr_q[0]),
        .word      (mem_rdata),
        .wbyte     (wbuf[7:0]),
        .ext_data  (ext_data),
        .merged    (merged)
    );

    assign mem_addr  = {addr_q[ADDR_W-1:1], 1'b0};
    assign mem_wdata = wbuf;
    // Misaligned word access, or a byte store while RMW is disabled.
    assign bad_req   = (~req_byte & req_addr[0]) | (req_we & req_byte & ~BYTE_ST_EN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_load  <= 1'b0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            signed_q  <= 1'b0;
            addr_q    <= '0;
            rd_q      <= '0;
            wbuf      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        byte_q    <= req_byte;
                        signed_q  <= req_signed;
                        addr_q    <= req_addr;
                        rd_q      <= req_rd;
                        wbuf      <= req_wdata;
                        if (bad_req) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_load  <= ~req_we;
                            rsp_rd    <= req_rd;
                            rsp_data  <= '0;
                        end else if (!req_we || req_byte) begin
                            state  <= S_RD;
                            mem_rd <= 1'b1;
                        end else begin
                            state  <= S_WR;
                            mem_wr <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    mem_rd <= 1'b0;
                    state  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (we_q) begin
                        wbuf   <= merged;
                        mem_wr <= 1'b1;
                        state  <= S_WR;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= ext_data;
                        rsp_rd    <= rd_q;
                        rsp_load  <= 1'b1;
                        rsp_err   <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                S_WR: begin
                    mem_wr    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                    rsp_rd    <= rd_q;
                    rsp_load  <= 1'b0;
                    rsp_err   <= 1'b0;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                        rsp_rd    <= '0;
                        rsp_load  <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// traffic against a word-array reference model of memory and response rules.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_rd = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready, rsp_valid, rsp_load, rsp_err, mem_rd, mem_wr;
    logic [15:0] rsp_data, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [3:0]  rsp_rd;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;

    logic [15:0] mem [0:255];
    logic [15:0] ref_mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [15:0] pre_val = '0;

    always #5 clk = ~clk;

    load_store_unit #(.BYTE_ST_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_load(rsp_load), .rsp_err(rsp_err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory device: registered read, posedge write, plus a bench preload port.
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (mem_wr) mem[mem_addr[8:1]] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr[8:1]];
    end

    always @(negedge clk) if (mem_wr) wr_cnt <= wr_cnt + 1;

    task automatic preload(input logic [7:0] idx, input logic [15:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_val = val;
        ref_mem[idx] = val;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issue one request and watch the strobes/response; k counts cycles after acceptance.
    task automatic run_txn(input logic we, input logic byt, input logic sgn,
                           input logic [15:0] addr, input logic [15:0] wdata, input logic [3:0] rd,
                           output int rd_k, output int wr_k, output int rsp_k,
                           output logic [15:0] wr_data, output logic [15:0] r_data,
                           output logic [3:0] r_rd, output logic r_load, output logic r_err);
        int n;
        rd_k = 0; wr_k = 0; rsp_k = 0; wr_data = '0; r_data = '0; r_rd = '0; r_load = 0; r_err = 0;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = we; req_byte = byt; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom; req_byte = $urandom; req_addr = 16'($urandom);
        req_wdata = 16'($urandom); req_rd = 4'($urandom);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_rd && rd_k == 0) rd_k = k;
            if (mem_wr && wr_k == 0) begin wr_k = k; wr_data = mem_wdata; end
            if (rsp_valid) begin
                rsp_k = k; r_data = rsp_data; r_rd = rsp_rd; r_load = rsp_load; r_err = rsp_err;
                break;
            end
        end
    endtask

    int rk, wk, pk;
    logic [15:0] wd, rdat;
    logic [3:0]  rrd;
    logic        rl, re;

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        total++; if ({rsp_valid, mem_rd, mem_wr, rsp_load, rsp_err} !== 5'b0) begin bad++; $display("FAIL reset_flags got %b want 00000", {rsp_valid, mem_rd, mem_wr, rsp_load, rsp_err}); end
        total++; if (rsp_data !== 16'h0 || mem_addr !== 16'h0) begin bad++; $display("FAIL reset_data got %h/%h want 0/0", rsp_data, mem_addr); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
    endtask

    task automatic test_word_load();
        preload(8'h08, 16'h8001);
        run_txn(0, 0, 0, 16'h0010, 16'h0, 4'd3, rk, wk, pk, wd, rdat, rrd, rl, re);
        total++; if (rk !== 1 || wk !== 0) begin bad++; $display("FAIL wload_strobes got rd@%0d wr@%0d want rd@1 wr@0", rk, wk); end
        total++; if (pk !== 3) begin bad++; $display("FAIL wload_latency got %0d want 3", pk); end
        total++; if (rdat !== 16'h8001) begin bad++; $display("FAIL wload_data got %h want 8001", rdat); end
        total++; if (rrd !== 4'd3 || rl !== 1'b1 || re !== 1'b0) begin bad++; $display("FAIL wload_tags got rd=%0d load=%b err=%b want 3 1 0", rrd, rl, re); end
    endtask

    task automatic test_byte_load();
        preload(8'h10, 16'h80F0);
        run_txn(0, 1, 1, 16'h0021, 16'h0, 4'd5, rk, wk, pk, wd, rdat, rrd, rl, re);
        total++; if (rdat !== 16'hFF80 || pk !== 3) begin bad++; $display("FAIL bload_signed got %h@%0d want ff80@3", rdat, pk); end
        run_txn(0, 1, 0, 16'h0020, 16'h0, 4'd6, rk, wk, pk, wd, rdat, rrd, rl, re);
        total++; if (rdat !== 16'h00F0 || rrd !== 4'd6) begin bad++; $display("FAIL bload_unsigned got %h rd=%0d want 00f0 rd=6", rdat, rrd); end
    endtask

    task automatic test_byte_store();
        preload(8'h20, 16'h1234);
        run_txn(1, 1, 0, 16'h0041, 16'h77AB, 4'd1, rk, wk, pk, wd, rdat, rrd, rl, re);
        total++; if (rk !== 1 || wk !== 3) begin bad++; $display("FAIL bstore_seq got rd@%0d wr@%0d want rd@1 wr@3", rk, wk); end
        total++; if (wd !== 16'hAB34) begin bad++; $display("FAIL bstore_wdata got %h want ab34", wd); end
        total++; if (pk !== 4 || re !== 1'b0 || rl !== 1'b0 || rdat !== 16'h0) begin bad++; $display("FAIL bstore_rsp got @%0d err=%b load=%b data=%h want @4 0 0 0000", pk, re, rl, rdat); end
        @(negedge clk);
        total++; if (mem[8'h20] !== 16'hAB34) begin bad++; $display("FAIL bstore_mem got %h want ab34", mem[8'h20]); end
        ref_mem[8'h20] = 16'hAB34;
    endtask

    task automatic test_misaligned();
        preload(8'h01, 16'h5A5A);
        run_txn(1, 0, 0, 16'h0003, 16'hFFFF, 4'd9, rk, wk, pk, wd, rdat, rrd, rl, re);
        total++; if (rk !== 0 || wk !== 0) begin bad++; $display("FAIL misal_strobes got rd@%0d wr@%0d want none", rk, wk); end
        total++; if (pk !== 1 || re !== 1'b1 || rl !== 1'b0 || rdat !== 16'h0) begin bad++; $display("FAIL misal_rsp got @%0d err=%b load=%b data=%h want @1 1 0 0000", pk, re, rl, rdat); end
        @(negedge clk);
        total++; if (mem[8'h01] !== 16'h5A5A) begin bad++; $display("FAIL misal_mem got %h want 5a5a", mem[8'h01]); end
        run_txn(0, 0, 0, 16'h0007, 16'h0, 4'd2, rk, wk, pk, wd, rdat, rrd, rl, re);
        total++; if (pk !== 1 || re !== 1'b1 || rl !== 1'b1 || rdat !== 16'h0) begin bad++; $display("FAIL misal_load got @%0d err=%b load=%b data=%h want @1 1 1 0000", pk, re, rl, rdat); end
    endtask

    task automatic test_back_pressure();
        preload(8'h30, 16'hC3A5);
        rsp_ready = 1'b0;
        run_txn(0, 0, 0, 16'h0060, 16'h0, 4'd7, rk, wk, pk, wd, rdat, rrd, rl, re);
        total++; if (pk !== 3 || rdat !== 16'hC3A5) begin bad++; $display("FAIL bp_first got %h@%0d want c3a5@3", rdat, pk); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'hC3A5 || rsp_rd !== 4'd7 || rsp_load !== 1'b1 || req_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc%0d got v=%b d=%h rd=%0d l=%b rdy=%b want 1 c3a5 7 1 0", i, rsp_valid, rsp_data, rsp_rd, rsp_load, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got v=%b rdy=%b want 0 1", rsp_valid, req_ready); end
        run_txn(1, 0, 0, 16'h0062, 16'hBEEF, 4'd8, rk, wk, pk, wd, rdat, rrd, rl, re);
        total++; if (pk !== 2 || wk !== 1 || wd !== 16'hBEEF || rrd !== 4'd8) begin bad++; $display("FAIL bp_next got @%0d wr@%0d %h rd=%0d want @2 wr@1 beef 8", pk, wk, wd, rrd); end
        ref_mem[8'h31] = 16'hBEEF;
    endtask

    task automatic test_reset_mid_rmw();
        int wr_before;
        preload(8'h40, 16'h9876);
        wr_before = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_addr = 16'h0080; req_wdata = 16'h0011; req_rd = 4'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({mem_rd, mem_wr, rsp_valid, req_ready} !== 4'b0 || mem_wdata !== 16'h0 || mem_addr !== 16'h0) begin
            bad++; $display("FAIL rmw_reset_outs got rd=%b wr=%b v=%b rdy=%b wd=%h a=%h want all 0", mem_rd, mem_wr, rsp_valid, req_ready, mem_wdata, mem_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (wr_cnt !== wr_before) begin bad++; $display("FAIL rmw_reset_wr got %0d writes want 0", wr_cnt - wr_before); end
        total++; if (mem[8'h40] !== 16'h9876 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rmw_reset_idle got mem=%h rdy=%b v=%b want 9876 1 0", mem[8'h40], req_ready, rsp_valid); end
        run_txn(0, 0, 0, 16'h0080, 16'h0, 4'd4, rk, wk, pk, wd, rdat, rrd, rl, re);
        total++; if (pk !== 3 || rdat !== 16'h9876) begin bad++; $display("FAIL rmw_reset_after got %h@%0d want 9876@3", rdat, pk); end
    endtask

    task automatic test_random();
        logic we, byt, sgn;
        logic [15:0] addr, wdata, old, lane, exp_data, exp_word;
        logic [3:0]  rd;
        logic        exp_err;
        int          exp_lat, exp_rk, sh;
        for (int i = 0; i < 256; i++) preload(8'(i), 16'($urandom));
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom); byt = 1'($urandom); sgn = 1'($urandom);
            addr = 16'($urandom_range(0, 511)); wdata = 16'($urandom); rd = 4'($urandom);
            old = ref_mem[addr[8:1]];
            sh = addr[0] ? 8 : 0;
            lane = (old >> sh) & 16'h00FF;
            exp_err = !byt && addr[0];
            exp_data = 16'h0; exp_word = old;
            if (exp_err) begin exp_lat = 1; exp_rk = 0; end
            else if (!we) begin
                exp_lat = 3; exp_rk = 1;
                exp_data = !byt ? old : ((sgn && lane >= 128) ? lane + 16'hFF00 : lane);
            end else if (byt) begin
                exp_lat = 4; exp_rk = 1;
                exp_word = (old & ~(16'h00FF << sh)) | ((wdata & 16'h00FF) << sh);
            end else begin
                exp_lat = 2; exp_rk = 0; exp_word = wdata;
            end
            run_txn(we, byt, sgn, addr, wdata, rd, rk, wk, pk, wd, rdat, rrd, rl, re);
            total++;
            if (pk !== exp_lat || rk !== exp_rk || rdat !== exp_data || rrd !== rd || rl !== !we || re !== exp_err) begin
                bad++; $display("FAIL rand%0d rsp got @%0d rd@%0d d=%h rd=%0d l=%b e=%b want @%0d rd@%0d d=%h rd=%0d l=%b e=%b",
                                i, pk, rk, rdat, rrd, rl, re, exp_lat, exp_rk, exp_data, rd, !we, exp_err);
            end
            if (we && !exp_err) begin
                total++;
                if (wd !== exp_word || wk !== exp_lat - 1) begin bad++; $display("FAIL rand%0d wr got %h@%0d want %h@%0d", i, wd, wk, exp_word, exp_lat - 1); end
                ref_mem[addr[8:1]] = exp_word;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            total++;
            if (mem[i] !== ref_mem[i]) begin bad++; $display("FAIL rand_mem[%0d] got %h want %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_byte_store();
        test_misaligned();
        test_back_pressure();
        test_reset_mid_rmw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
